counter_with_strobe_multi: RTL and testbench

Multi-channel successor to the single-channel pipelined strobe counter. Each of CHANNELS independent down-counters counts accepted enable ticks and emits a one-cycle strobe after every reset_value ticks, with fixed pipeline latency LATENCY. Each channel adds a per-channel load (re-arm) input and a one-shot mode. It sits between clock-enable/tick generators and timing consumers such as baud, PWM and timeout logic.

---
 rtl/counter_with_strobe_multi.sv | 137 +++++++++++++
 tb/tb_counter_with_strobe_multi.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_with_strobe_multi.sv
// -----------------------------------------------------------------------------
// counter_with_strobe_multi
//
// CHANNELS independent pipelined down-counters. Each channel counts accepted
// enable ticks and emits a one-cycle strobe LATENCY cycles after every
// reset_value-th tick. The channel supports a re-arm (load) and a one-shot mode
// that stops after the first terminal count.
//
// Ports:
//   clk          in   1               clock, all logic on posedge
//   rst          in   1               synchronous reset, active-low
//   enable       in   CHANNELS        per-channel tick request
//   reset_value  in   CHANNELS*WIDTH  per-channel period, 0 means 2^WIDTH
//   load         in   CHANNELS        per-channel re-arm from reset_value
//   one_shot     in   CHANNELS        1 = stop after first terminal count
//   ready        out  CHANNELS        channel accepts a tick this cycle
//   strobe       out  CHANNELS        one-cycle terminal-count pulse
//   valid        out  CHANNELS        channel settled and armed
//   done         out  CHANNELS        one-shot channel has expired
// -----------------------------------------------------------------------------
module counter_with_strobe_multi #(
  parameter int WIDTH    = 4,
  parameter int LATENCY  = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] reset_value,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       one_shot,
  output logic [CHANNELS-1:0]       ready,
  output logic [CHANNELS-1:0]       strobe,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       done
);

  localparam int                WAIT_W    = $clog2(LATENCY + 1);
  // Settling after a load lasts LATENCY cycles; the gap after a tick is one less.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_TICK = WAIT_W'(LATENCY - 1);

  // High for the first edge after reset is released; acts as a load on every
  // channel so counting restarts cleanly after any reset.
  logic r_init_load;

  // NOTE: state is only ever updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) r_init_load <= 1'b1;
    else      r_init_load <= 1'b0;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0]   r_cnt;        // ticks remaining until terminal
    logic [WAIT_W-1:0]  r_wait;       // cycles until ready/valid rise
    logic [LATENCY-1:0] r_pipe_stb;   // in-flight terminal ticks
    logic [LATENCY-1:0] r_pipe_done;  // in-flight one-shot expirations
    logic               r_ready;
    logic               r_valid;
    logic               r_strobe;
    logic               r_done;

    logic [WIDTH-1:0]   w_period;
    logic               w_load;
    logic               w_accept;
    logic               w_terminal;

    assign w_period   = reset_value[g*WIDTH +: WIDTH];
    assign w_load     = load[g] | r_init_load;
    // Load wins over a simultaneous tick.
    assign w_accept   = enable[g] & r_ready & r_valid & ~w_load;
    // A period of 0 loads 0, which wraps to all-ones on the first tick and
    // reaches 1 after 2^WIDTH-1 ticks, giving the full 2^WIDTH period.
    assign w_terminal = (r_cnt == WIDTH'(1));

    always_ff @(posedge clk) begin
      if (!rst) begin
        // NOTE: the strobe pipeline is reset along with the counters because
        // a stale in-flight strobe must never escape after reset.
        r_cnt       <= '0;
        r_wait      <= '0;
        r_pipe_stb  <= '0;
        r_pipe_done <= '0;
        r_ready     <= 1'b0;
        r_valid     <= 1'b0;
        r_strobe    <= 1'b0;
        r_done      <= 1'b0;
      end else if (w_load) begin
        r_cnt       <= w_period;
        r_wait      <= WAIT_LOAD;
        r_pipe_stb  <= '0;
        r_pipe_done <= '0;
        r_ready     <= 1'b0;
        r_valid     <= 1'b0;
        r_strobe    <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        for (int k = LATENCY - 1; k > 0; k--) begin
          r_pipe_stb[k]  <= r_pipe_stb[k-1];
          r_pipe_done[k] <= r_pipe_done[k-1];
        end
        r_pipe_stb[0]  <= w_accept & w_terminal;
        r_pipe_done[0] <= w_accept & w_terminal & one_shot[g];
        r_strobe       <= r_pipe_stb[LATENCY-1];
        r_done         <= r_done | r_pipe_done[LATENCY-1];

        if (r_wait != '0) begin
          r_wait <= r_wait - WAIT_W'(1);
          if (r_wait == WAIT_W'(1)) begin
            r_ready <= 1'b1;
            r_valid <= 1'b1;
          end
        end

        // r_wait is always zero here since a tick needs ready=1.
        if (w_accept) begin
          if (w_terminal && one_shot[g]) begin
            // Expired: stay blocked until the next load.
            r_ready <= 1'b0;
            r_wait  <= '0;
          end else if (LATENCY > 1) begin
            r_ready <= 1'b0;
            r_wait  <= WAIT_TICK;
          end
          r_cnt <= w_terminal ? w_period : r_cnt - WIDTH'(1);
        end
      end
    end

    assign ready[g]  = r_ready;
    assign valid[g]  = r_valid;
    assign strobe[g] = r_strobe;
    assign done[g]   = r_done;
  end

endmodule

// File: tb/tb_counter_with_strobe_multi.sv
// -----------------------------------------------------------------------------
// tb_counter_with_strobe_multi
//
// Self-checking bench. A time-stamp reference model predicts, per channel,
// the edge at which ready/valid rise, the edge of each pending strobe and the
// edge of one-shot expiry; DUT outputs are compared against it every cycle.
// A second instance with LATENCY=1 covers the full-rate case.
// -----------------------------------------------------------------------------
module tb_counter_with_strobe_multi;

  localparam int W   = 4;
  localparam int LAT = 4;
  localparam int CH  = 2;
  localparam int INF = 1 << 30;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH-1:0]   enable = '0;
  logic [CH-1:0]   load = '0;
  logic [CH-1:0]   one_shot = '0;
  logic [CH*W-1:0] reset_value = '0;
  logic [CH-1:0]   ready, strobe, valid, done;

  logic [CH-1:0]   enable1 = 2'b01;
  logic [CH-1:0]   load1 = '0;
  logic [CH-1:0]   one_shot1 = '0;
  logic [CH*W-1:0] reset_value1 = {4'd0, 4'd4};
  logic [CH-1:0]   ready1, strobe1, valid1, done1;

  always #5 clk = ~clk;

  counter_with_strobe_multi #(.WIDTH(W), .LATENCY(LAT), .CHANNELS(CH)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .reset_value(reset_value),
    .load(load), .one_shot(one_shot),
    .ready(ready), .strobe(strobe), .valid(valid), .done(done)
  );

  counter_with_strobe_multi #(.WIDTH(W), .LATENCY(1), .CHANNELS(CH)) u_dut_l1 (
    .clk(clk), .rst(rst), .enable(enable1), .reset_value(reset_value1),
    .load(load1), .one_shot(one_shot1),
    .ready(ready1), .strobe(strobe1), .valid(valid1), .done(done1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=0x%0h want=0x%0h", tag, n_edge, obs, exp);
    end
  endtask

  // Reference model: absolute edge numbers at which things happen.
  int m_ready_at [CH];
  int m_valid_at [CH];
  int m_done_at  [CH];
  int m_stb_at   [CH];
  int m_left     [CH];
  bit m_exp_stb  [CH];
  bit m_first = 1'b0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_ready_at[c] = INF; m_valid_at[c] = INF; m_done_at[c] = INF;
      m_stb_at[c] = -1; m_left[c] = 0; m_exp_stb[c] = 1'b0;
    end
  end

  task automatic model_edge();
    n_edge++;
    for (int c = 0; c < CH; c++) begin
      int period;
      bit rdy;
      bit ld;
      logic [W-1:0] rv;
      rv     = reset_value[c*W +: W];
      period = (rv == '0) ? (1 << W) : int'(rv);
      rdy    = (n_edge - 1 >= m_ready_at[c]) && (n_edge - 1 >= m_valid_at[c]);
      ld     = load[c] || m_first;
      m_exp_stb[c] = rst && !ld && (m_stb_at[c] == n_edge);
      if (!rst) begin
        m_ready_at[c] = INF; m_valid_at[c] = INF; m_done_at[c] = INF; m_stb_at[c] = -1;
      end else if (ld) begin
        m_left[c] = period;
        m_ready_at[c] = n_edge + LAT; m_valid_at[c] = n_edge + LAT;
        m_done_at[c] = INF; m_stb_at[c] = -1;
      end else if (enable[c] && rdy) begin
        m_left[c]--;
        m_ready_at[c] = n_edge + LAT - 1;
        if (m_left[c] == 0) begin
          m_left[c]   = period;
          m_stb_at[c] = n_edge + LAT;
          if (one_shot[c]) begin
            m_ready_at[c] = INF;
            m_done_at[c]  = n_edge + LAT;
          end
        end
      end
    end
    m_first = !rst;
  endtask

  // One clock: model advances at the edge, DUT is sampled at the falling edge.
  task automatic cycle();
    logic [CH-1:0] er, ev, es, ed;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      er[c] = (n_edge >= m_ready_at[c]);
      ev[c] = (n_edge >= m_valid_at[c]);
      es[c] = m_exp_stb[c];
      ed[c] = (n_edge >= m_done_at[c]);
    end
    check("ready",  32'(ready),  32'(er));
    check("valid",  32'(valid),  32'(ev));
    check("strobe", 32'(strobe), 32'(es));
    check("done",   32'(done),   32'(ed));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  int s_edges[$];
  int l1_edges[$];
  int mark;
  int waited;
  int cnt;

  initial begin
    // 1. Reset, release, periodic pulsed ticks on ch0.
    rst = 1'b0;
    run(2);
    check("rst_outputs", 32'({ready, valid, strobe, done}), 32'd0);
    reset_value = {4'd3, 4'd4};
    rst = 1'b1;
    s_edges.delete();
    for (int i = 0; i < 400 && s_edges.size() < 10; i++) begin
      enable[0] = ready[0] && !enable[0];
      cycle();
      if (strobe[0]) s_edges.push_back(n_edge);
    end
    check("p1_strobe_count", 32'(s_edges.size()), 32'd10);
    for (int i = 1; i < s_edges.size(); i++)
      check("p1_spacing", 32'(s_edges[i] - s_edges[i-1]), 32'(4 * LAT));

    // 2. Continuous enable on ch0; LATENCY=1 instance accepts every cycle.
    enable[0] = 1'b1;
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    l1_edges.delete();
    for (int i = 0; i < 80; i++) begin
      cycle();
      check("l1_ready", 32'(ready1), 32'(2'b11));
      check("l1_valid", 32'(valid1), 32'(2'b11));
      check("l1_done",  32'(done1),  32'd0);
      check("l1_ch1_strobe", 32'(strobe1[1]), 32'd0);
      if (strobe1[0]) l1_edges.push_back(n_edge);
    end
    check("l1_strobe_count", 32'(l1_edges.size()), 32'd20);
    for (int i = 1; i < l1_edges.size(); i++)
      check("l1_spacing", 32'(l1_edges[i] - l1_edges[i-1]), 32'd4);

    // 3. One-shot on ch1 while ch0 keeps running.
    reset_value[7:4] = 4'd3;
    one_shot[1] = 1'b1;
    enable[1] = 1'b1;
    load[1] = 1'b1;
    cycle();
    load[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (strobe[1]) cnt++;
    end
    check("p3_oneshot_count", 32'(cnt), 32'd1);
    check("p3_done", 32'(done[1]), 32'd1);
    check("p3_ready_low", 32'(ready[1]), 32'd0);
    load[1] = 1'b1;
    cycle();
    load[1] = 1'b0;
    check("p3_done_cleared", 32'(done[1]), 32'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (strobe[1]) cnt++;
    end
    check("p3_rearm_count", 32'(cnt), 32'd1);
    enable[1] = 1'b0;

    // 4. Full-range period, then a mid-period change to 15.
    reset_value[3:0] = 4'd0;
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    mark = n_edge;
    s_edges.delete();
    for (int i = 0; i < 150; i++) begin
      if (i == 20) reset_value[3:0] = 4'd15;
      cycle();
      if (strobe[0]) s_edges.push_back(n_edge);
    end
    check("p4_strobe_count", 32'(s_edges.size()), 32'd2);
    if (s_edges.size() >= 2) begin
      check("p4_first_period",  32'(s_edges[0] - mark), 32'(16 * LAT + LAT + 1));
      check("p4_second_period", 32'(s_edges[1] - s_edges[0]), 32'(15 * LAT));
    end

    // 5. Load two cycles after a terminal tick cancels its strobe.
    reset_value[3:0] = 4'd2;
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    waited = 0;
    while (waited < 40 && m_stb_at[0] != n_edge + LAT) begin
      cycle();
      waited++;
    end
    check("p5_terminal_wait", 32'(waited < 40), 32'd1);
    cycle();
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (strobe[0]) cnt++;
    end
    check("p5_cancelled", 32'(cnt), 32'd0);
    // load together with an acceptable tick: the tick is dropped.
    waited = 0;
    while (waited < 20 && !(n_edge >= m_ready_at[0] && n_edge >= m_valid_at[0])) begin
      cycle();
      waited++;
    end
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    mark = n_edge;
    s_edges.delete();
    for (int i = 0; i < 30 && s_edges.size() == 0; i++) begin
      cycle();
      if (strobe[0]) s_edges.push_back(n_edge);
    end
    check("p5_drop_count", 32'(s_edges.size()), 32'd1);
    if (s_edges.size() >= 1)
      check("p5_drop_latency", 32'(s_edges[0] - mark), 32'(2 * LAT + LAT + 1));

    // 6. Reset one cycle after a terminal tick.
    reset_value[3:0] = 4'd3;
    load[0] = 1'b1;
    cycle();
    load[0] = 1'b0;
    waited = 0;
    while (waited < 40 && m_stb_at[0] != n_edge + LAT) begin
      cycle();
      waited++;
    end
    check("p6_terminal_wait", 32'(waited < 40), 32'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("p6_rst_outputs", 32'({ready, valid, strobe, done}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (strobe[0]) cnt++;
    end
    check("p6_no_stale", 32'(cnt), 32'd0);
    run(30);
    enable = '0;

    // 7. Random traffic on both channels.
    for (int i = 0; i < 800; i++) begin
      enable   = CH'($urandom);
      load     = {CH{1'b0}};
      for (int c = 0; c < CH; c++) begin
        load[c] = ($urandom_range(0, 23) == 0);
        if ($urandom_range(0, 31) == 0) one_shot[c] = ~one_shot[c];
        if ($urandom_range(0, 15) == 0) reset_value[c*W +: W] = W'($urandom);
      end
      rst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst = 1'b1;
    load = '0;
    enable = '0;
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
